// File: rtl/rtmr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rtmr_pkg
//  Purpose  : Shared types and default constants for the reaction timer.
//  Revision : 1.0 - initial release
// ============================================================================
package rtmr_pkg;

   // Game phases of one reaction round
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REACT  = 2'd2,
      RESULT = 2'd3
   } rtmr_state_t;

   // Defaults for a 50 MHz clock and one-second windows
   localparam int C_TICK_DIV = 50000;
   localparam int C_MIN_MS   = 1000;
   localparam int C_MAX_MS   = 1000;

endpackage : rtmr_pkg
`default_nettype wire

// File: rtl/ms_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : ms_tick_gen
//  Purpose  : Millisecond prescaler. Counts 0..TICK_DIV-1 and flags the last
//             count as a one-cycle tick; a synchronous clear restarts it.
//  Revision : 1.0 - initial release
// ============================================================================
module ms_tick_gen
   import rtmr_pkg::*;
#(
   parameter int TICK_DIV = C_TICK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int             CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  C_LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Tick is the decode of the final count so the consumer sees it the
   // same cycle the counter sits at TICK_DIV-1
   assign tick = (r_cnt == C_LAST);

   // Free-running divider, restarted on clear so a round aligns to start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr || tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule : ms_tick_gen
`default_nettype wire

// File: rtl/reaction_timer.sv
`default_nettype none
// ============================================================================
//  Module   : reaction_timer
//  Purpose  : Reaction-time game core. On start waits MIN_MS + random ms,
//             lights led, then measures the time to stop in ms. Early press
//             and timeout are flagged; results are held until next start.
//  Options  : RTMR_BEST_EN - keep a best-valid-reaction register on best_ms;
//             otherwise best_ms is tied to all ones.
//  Revision : 1.0 - initial release
// ============================================================================
module reaction_timer
   import rtmr_pkg::*;
#(
   parameter int N        = 14,
   parameter int DLY_BITS = 11,
   parameter int MIN_MS   = C_MIN_MS,
   parameter int TICK_DIV = C_TICK_DIV,
   parameter int MAX_MS   = C_MAX_MS,
   parameter int RW       = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stop,
   input  logic [N-1:0]  rnd,
   output logic          busy,
   output logic          led,
   output logic          done,
   output logic          early,
   output logic          timeout,
   output logic [RW-1:0] react_ms,
   output logic [RW-1:0] best_ms
);

   // Delay counter must hold MIN_MS + 2**DLY_BITS - 1
   localparam int DW = $clog2(MIN_MS + 2**DLY_BITS);

   rtmr_state_t   r_state, w_state_nxt;
   logic [DW-1:0] r_dly_cnt, w_dly_nxt;
   logic [RW-1:0] r_react_ms, w_react_nxt;
   logic          r_led, w_led_nxt;
   logic          r_done, w_done_nxt;
   logic          r_early, w_early_nxt;
   logic          r_timeout, w_timeout_nxt;
   logic          r_busy;
   logic          w_tick;
   logic          w_start_acc;

   // Start only counts in the idle-like states; it also realigns the prescaler
   assign w_start_acc = start && ((r_state == IDLE) || (r_state == RESULT));

   ms_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_start_acc),
      .tick  (w_tick)
   );

   // Upper PRBS bits do not feed the delay
   generate
      if (DLY_BITS < N) begin : g_rnd_spare
         logic w_unused_rnd;
         assign w_unused_rnd = ^rnd[N-1:DLY_BITS];
      end
   endgenerate

   // Next-state and next-result decisions; stop beats a coincident tick
   always_comb begin
      w_state_nxt   = r_state;
      w_dly_nxt     = r_dly_cnt;
      w_react_nxt   = r_react_ms;
      w_led_nxt     = r_led;
      w_done_nxt    = r_done;
      w_early_nxt   = r_early;
      w_timeout_nxt = r_timeout;

      case (r_state)
         IDLE, RESULT: begin
            if (start) begin
               w_state_nxt   = DELAY;
               w_dly_nxt     = DW'(MIN_MS) + DW'(rnd[DLY_BITS-1:0]);
               w_react_nxt   = '0;
               w_led_nxt     = 1'b0;
               w_done_nxt    = 1'b0;
               w_early_nxt   = 1'b0;
               w_timeout_nxt = 1'b0;
            end
         end
         DELAY: begin
            if (stop) begin
               w_state_nxt = RESULT;
               w_early_nxt = 1'b1;
               w_react_nxt = '0;
            end else if (w_tick) begin
               w_dly_nxt = r_dly_cnt - DW'(1);
               if (r_dly_cnt == DW'(1)) begin
                  w_state_nxt = REACT;
                  w_led_nxt   = 1'b1;
                  w_react_nxt = '0;
               end
            end
         end
         REACT: begin
            if (stop) begin
               w_state_nxt = RESULT;
               w_done_nxt  = 1'b1;
               w_led_nxt   = 1'b0;
            end else if (w_tick) begin
               if (r_react_ms + RW'(1) == RW'(MAX_MS)) begin
                  w_state_nxt   = RESULT;
                  w_timeout_nxt = 1'b1;
                  w_led_nxt     = 1'b0;
                  w_react_nxt   = RW'(MAX_MS);
               end else begin
                  w_react_nxt = r_react_ms + RW'(1);
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dly_cnt  <= '0;
         r_react_ms <= '0;
         r_led      <= 1'b0;
         r_done     <= 1'b0;
         r_early    <= 1'b0;
         r_timeout  <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_dly_cnt  <= w_dly_nxt;
         r_react_ms <= w_react_nxt;
         r_led      <= w_led_nxt;
         r_done     <= w_done_nxt;
         r_early    <= w_early_nxt;
         r_timeout  <= w_timeout_nxt;
         r_busy     <= (w_state_nxt == DELAY) || (w_state_nxt == REACT);
      end
   end

`ifdef RTMR_BEST_EN
   logic [RW-1:0] r_best_ms;
   logic          w_best_upd;

   // A valid stop ends the round with react_ms frozen at its current value
   assign w_best_upd = (r_state == REACT) && stop && (r_react_ms < r_best_ms);

   // Best valid reaction; only reset returns it to all ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_ms <= '1;
      end else if (w_best_upd) begin
         r_best_ms <= r_react_ms;
      end
   end

   assign best_ms = r_best_ms;
`else
   assign best_ms = '1;
`endif

   assign busy     = r_busy;
   assign led      = r_led;
   assign done     = r_done;
   assign early    = r_early;
   assign timeout  = r_timeout;
   assign react_ms = r_react_ms;

endmodule : reaction_timer
`default_nettype wire
